// File: rtl/cdc_app_pkg.sv
// Shared mode/ASCII constants and the per-byte transform for the CDC loopback engine.
// Pure combinational helpers; no latency, no flow control.
// Backpressure: not applicable (package only).
package cdc_app_pkg;

    localparam logic [1:0] MODE_PASS      = 2'd0;
    localparam logic [1:0] MODE_LOWER_INC = 2'd1;
    localparam logic [1:0] MODE_UPPER     = 2'd2;
    localparam logic [1:0] MODE_LINE      = 2'd3;

    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_A  = 8'h41;
    localparam logic [7:0] ASCII_Z  = 8'h5A;
    localparam logic [7:0] ASCII_a  = 8'h61;
    localparam logic [7:0] ASCII_z  = 8'h7A;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_9  = 8'h39;

    function automatic logic [7:0] xform(input logic [7:0] b, input logic [1:0] mode);
        logic [7:0] r;
        r = b;
        case (mode)
            MODE_LOWER_INC: begin
                if (b >= ASCII_A && b <= ASCII_Z) r = b + 8'h20;
                else if (b >= ASCII_0 && b < ASCII_9) r = b + 8'h01;
                else if (b == ASCII_9) r = ASCII_0;
            end
            MODE_UPPER: begin
                if (b >= ASCII_a && b <= ASCII_z) r = b - 8'h20;
            end
            default: r = b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/xform_fifo.sv
// One loopback channel: transforming FIFO with a committed-count gate for line buffering.
// Latency: a committed byte is visible the cycle after the edge that wrote/committed it.
// Backpressure: wr_rdy_o drops when full and recovers one cycle after a read (registered).
module xform_fifo
    import cdc_app_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic [7:0]               wr_dat_i,
    input  logic                     wr_vld_i,
    output logic                     wr_rdy_o,
    output logic [7:0]               rd_dat_o,
    output logic                     rd_vld_o,
    input  logic                     rd_rdy_i,
    input  logic [1:0]               mode_i,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] ccnt_q, ccnt_d;
    logic          wr, rd, commit;

    always_comb begin
        wr       = wr_vld_i && (cnt_q != FULL);
        rd       = rd_rdy_i && (ccnt_q != '0);
        wr_ptr_d = wr ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = rd ? rd_ptr_q + PW'(1) : rd_ptr_q;
        cnt_d    = cnt_q + CW'(wr) - CW'(rd);
        // Outside LINE everything is committed; inside, only LF or filling up releases the line.
        commit   = (mode_i != MODE_LINE) ||
                   (wr && ((wr_dat_i == ASCII_LF) || (cnt_d == FULL)));
        ccnt_d   = commit ? cnt_d : ccnt_q - CW'(rd);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ccnt_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ccnt_q   <= ccnt_d;
        end
    end

    // Transform on write so later mode changes never touch stored bytes.
    always_ff @(posedge clk_i) begin
        if (wr) mem_q[wr_ptr_q] <= xform(wr_dat_i, mode_i);
    end

    assign wr_rdy_o = (cnt_q != FULL);
    assign rd_vld_o = (ccnt_q != '0);
    assign rd_dat_o = mem_q[rd_ptr_q];
    assign level_o  = cnt_q;

endmodule

// File: rtl/cdc_xform_loopback.sv
// Multi-channel CDC loopback: independent transforming FIFOs, one per channel, no arbitration.
// Latency: one cycle write-to-read when committed; LINE mode waits for LF, full, or mode exit.
// Backpressure: per-channel ready is registered occupancy; nothing passes combinationally.
module cdc_xform_loopback
    import cdc_app_pkg::*;
#(
    parameter int CHANNELS = 1,
    parameter int DEPTH    = 16
) (
    input  logic                                  clk_i,
    input  logic                                  rstn_i,
    input  logic [8*CHANNELS-1:0]                 out_data_i,
    input  logic [CHANNELS-1:0]                   out_valid_i,
    output logic [CHANNELS-1:0]                   out_ready_o,
    output logic [8*CHANNELS-1:0]                 in_data_o,
    output logic [CHANNELS-1:0]                   in_valid_o,
    input  logic [CHANNELS-1:0]                   in_ready_i,
    input  logic [2*CHANNELS-1:0]                 mode_i,
    output logic [CHANNELS*($clog2(DEPTH)+1)-1:0] level_o
);

    localparam int LW = $clog2(DEPTH) + 1;

    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        xform_fifo #(
            .DEPTH(DEPTH)
        ) u_fifo (
            .clk_i    (clk_i),
            .rstn_i   (rstn_i),
            .wr_dat_i (out_data_i[8*n +: 8]),
            .wr_vld_i (out_valid_i[n]),
            .wr_rdy_o (out_ready_o[n]),
            .rd_dat_o (in_data_o[8*n +: 8]),
            .rd_vld_o (in_valid_o[n]),
            .rd_rdy_i (in_ready_i[n]),
            .mode_i   (mode_i[2*n +: 2]),
            .level_o  (level_o[LW*n +: LW])
        );
    end

endmodule

// File: tb/tb_cdc_xform_loopback.sv
// Randomised and directed bench for cdc_xform_loopback against a queue-based reference model.
module tb_cdc_xform_loopback;

    localparam int CH    = 3;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    typedef logic [7:0] bq_t[$];

    logic                 clk_i = 1'b0;
    logic                 rstn_i;
    logic [8*CH-1:0]      out_data_i;
    logic [CH-1:0]        out_valid_i;
    logic [CH-1:0]        out_ready_o;
    logic [8*CH-1:0]      in_data_o;
    logic [CH-1:0]        in_valid_o;
    logic [CH-1:0]        in_ready_i;
    logic [2*CH-1:0]      mode_i;
    logic [CH*LW-1:0]     level_o;

    int total = 0;
    int bad   = 0;

    logic [7:0] mq  [CH][$];
    int         mc  [CH];
    logic [7:0] got [CH][$];

    always #5 clk_i = ~clk_i;

    cdc_xform_loopback #(
        .CHANNELS(CH),
        .DEPTH   (DEPTH)
    ) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .out_data_i  (out_data_i),
        .out_valid_i (out_valid_i),
        .out_ready_o (out_ready_o),
        .in_data_o   (in_data_o),
        .in_valid_o  (in_valid_o),
        .in_ready_i  (in_ready_i),
        .mode_i      (mode_i),
        .level_o     (level_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Reference transform written straight from the mode table.
    function automatic logic [7:0] ref_xform(input logic [7:0] b, input int mode);
        int v;
        v = b;
        if (mode == 1) begin
            if (v >= "A" && v <= "Z") v = v + 32;
            else if (v >= "0" && v <= "9") v = (v == "9") ? "0" : v + 1;
        end else if (mode == 2) begin
            if (v >= "a" && v <= "z") v = v - 32;
        end
        return 8'(v);
    endfunction

    function automatic bq_t str2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    task automatic model_clear();
        for (int c = 0; c < CH; c++) begin
            mq[c].delete();
            mc[c] = 0;
        end
    endtask

    task automatic compare_all();
        for (int c = 0; c < CH; c++) begin
            chk($sformatf("rdy%0d", c), 32'(out_ready_o[c]), 32'(mq[c].size() < DEPTH));
            chk($sformatf("vld%0d", c), 32'(in_valid_o[c]), 32'(mc[c] > 0));
            chk($sformatf("lvl%0d", c), 32'(level_o[c*LW +: LW]), 32'(mq[c].size()));
            if (mc[c] > 0) chk($sformatf("dat%0d", c), 32'(in_data_o[c*8 +: 8]), 32'(mq[c][0]));
        end
    endtask

    // One clock: predict transfers from pre-edge inputs, advance the model, then compare.
    task automatic cycle();
        bit         acc [CH];
        bit         tak [CH];
        logic [7:0] raw [CH];
        int         md  [CH];
        for (int c = 0; c < CH; c++) begin
            acc[c] = out_valid_i[c] && (mq[c].size() < DEPTH);
            tak[c] = in_ready_i[c] && (mc[c] > 0);
            raw[c] = out_data_i[c*8 +: 8];
            md[c]  = int'(mode_i[c*2 +: 2]);
            if (tak[c] && rstn_i) got[c].push_back(in_data_o[c*8 +: 8]);
        end
        @(posedge clk_i);
        #1;
        if (!rstn_i) begin
            model_clear();
        end else begin
            for (int c = 0; c < CH; c++) begin
                if (tak[c]) begin
                    void'(mq[c].pop_front());
                    mc[c]--;
                end
                if (acc[c]) mq[c].push_back(ref_xform(raw[c], md[c]));
                if (md[c] != 3) mc[c] = mq[c].size();
                else if (acc[c] && (raw[c] == 8'h0A || mq[c].size() == DEPTH)) mc[c] = mq[c].size();
            end
        end
        compare_all();
    endtask

    task automatic send(input int c, input bq_t q);
        for (int i = 0; i < q.size(); i++) begin
            int tries;
            bit done;
            tries = 0;
            done  = 0;
            while (!done) begin
                out_valid_i[c] = 1'b1;
                out_data_i[c*8 +: 8] = q[i];
                done = (mq[c].size() < DEPTH);
                cycle();
                tries++;
                if (!done && tries > 50) begin
                    chk($sformatf("send_timeout%0d", c), 32'(tries), 32'd0);
                    done = 1;
                end
            end
        end
        out_valid_i[c] = 1'b0;
    endtask

    task automatic expect_rx(input int c, input string tag, input bq_t exp, input int budget);
        int n;
        n = 0;
        while (got[c].size() < exp.size() && n < budget) begin
            cycle();
            n++;
        end
        chk({tag, "_count"}, 32'(got[c].size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < got[c].size(); i++)
            chk($sformatf("%s[%0d]", tag, i), 32'(got[c][i]), 32'(exp[i]));
        got[c].delete();
    endtask

    initial begin
        bq_t q;
        int  maxlvl;
        int  mism;

        rstn_i      = 1'b0;
        out_data_i  = '0;
        out_valid_i = '0;
        in_ready_i  = '0;
        mode_i      = '0;
        model_clear();
        #2;
        chk("reset_rdy", 32'(out_ready_o), 32'h7);
        chk("reset_vld", 32'(in_valid_o), 32'h0);
        chk("reset_lvl", 32'(level_o), 32'h0);
        repeat (2) cycle();
        rstn_i = 1'b1;

        // Reset in the middle of traffic discards everything already stored.
        for (int i = 0; i < 3; i++) begin
            out_valid_i = 3'b011;
            out_data_i  = {8'h00, 8'(8'h50 + i), 8'(8'h40 + i)};
            cycle();
        end
        out_valid_i = '0;
        #2 rstn_i = 1'b0;
        #1;
        model_clear();
        chk("midrst_rdy", 32'(out_ready_o), 32'h7);
        chk("midrst_vld", 32'(in_valid_o), 32'h0);
        chk("midrst_lvl", 32'(level_o), 32'h0);
        cycle();
        cycle();
        rstn_i     = 1'b1;
        in_ready_i = '1;
        repeat (5) cycle();
        chk("post_rst_rx0", 32'(got[0].size()), 32'd0);
        chk("post_rst_rx1", 32'(got[1].size()), 32'd0);

        // LOWER_INC on channel 0.
        mode_i[1:0] = 2'd1;
        send(0, str2q("12345678"));
        expect_rx(0, "inc_digits", str2q("23456789"), 20);
        send(0, str2q("ABCDEFGH"));
        expect_rx(0, "inc_upper", str2q("abcdefgh"), 20);
        send(0, str2q("9~"));
        expect_rx(0, "inc_wrap", str2q("0~"), 20);

        // Fill channel 1 with the reader stalled.
        mode_i[3:2]   = 2'd0;
        in_ready_i[1] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            out_valid_i[1] = 1'b1;
            out_data_i[15:8] = 8'(i + 1);
            cycle();
            if (i == 7) chk("full_rdy_low", 32'(out_ready_o[1]), 32'd0);
        end
        out_valid_i[1] = 1'b0;
        chk("full_level", 32'(level_o[LW +: LW]), 32'd8);
        chk("full_no_rx", 32'(got[1].size()), 32'd0);
        in_ready_i[1] = 1'b1;
        chk("rdy_low_in_read_cycle", 32'(out_ready_o[1]), 32'd0);
        cycle();
        in_ready_i[1] = 1'b0;
        chk("one_read_count", 32'(got[1].size()), 32'd1);
        chk("one_read_byte", 32'(got[1][0]), 32'h01);
        chk("rdy_after_read", 32'(out_ready_o[1]), 32'd1);
        got[1].delete();
        in_ready_i[1] = 1'b1;
        q = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        expect_rx(1, "full_drain", q, 20);

        // LINE mode on channel 2.
        mode_i[5:4]   = 2'd3;
        in_ready_i[2] = 1'b1;
        send(2, str2q("abc"));
        repeat (20) cycle();
        chk("line_held_vld", 32'(in_valid_o[2]), 32'd0);
        chk("line_held_rx", 32'(got[2].size()), 32'd0);
        send(2, str2q("\n"));
        chk("line_lf_vld", 32'(in_valid_o[2]), 32'd1);
        expect_rx(2, "line_lf", str2q("abc\n"), 20);
        in_ready_i[2] = 1'b0;
        send(2, str2q("ABCDEFG"));
        chk("line_7_held", 32'(in_valid_o[2]), 32'd0);
        send(2, str2q("H"));
        chk("line_full_vld", 32'(in_valid_o[2]), 32'd1);
        chk("line_full_lvl", 32'(level_o[2*LW +: LW]), 32'd8);
        in_ready_i[2] = 1'b1;
        expect_rx(2, "line_full", str2q("ABCDEFGH"), 20);

        // All channels at once, different modes, then leave LINE on channel 2.
        in_ready_i = '1;
        repeat (12) cycle();
        for (int c = 0; c < CH; c++) got[c].delete();
        mode_i = {2'd3, 2'd2, 2'd0};
        q = str2q("aZ9");
        for (int i = 0; i < 3; i++) begin
            out_valid_i = '1;
            out_data_i  = {q[i], q[i], q[i]};
            cycle();
        end
        out_valid_i = '0;
        repeat (5) cycle();
        chk("indep_held_rx", 32'(got[2].size()), 32'd0);
        expect_rx(0, "indep_pass", str2q("aZ9"), 10);
        expect_rx(1, "indep_upper", str2q("AZ9"), 10);
        mode_i[5:4] = 2'd0;
        expect_rx(2, "indep_release", str2q("aZ9"), 10);

        // Sustained streaming on channel 0.
        mode_i = '0;
        in_ready_i = '1;
        repeat (4) cycle();
        got[0].delete();
        maxlvl = 0;
        for (int i = 0; i < 257; i++) begin
            out_valid_i[0] = (i < 256);
            out_data_i[7:0] = 8'(i);
            cycle();
            if (int'(level_o[LW-1:0]) > maxlvl) maxlvl = int'(level_o[LW-1:0]);
        end
        out_valid_i[0] = 1'b0;
        chk("stream_count", 32'(got[0].size()), 32'd256);
        chk("stream_maxlvl_le1", 32'(maxlvl <= 1), 32'd1);
        mism = 0;
        for (int i = 0; i < got[0].size(); i++) if (got[0][i] !== 8'(i)) mism++;
        chk("stream_data_mism", 32'(mism), 32'd0);

        // Randomised traffic over all channels, checked each cycle by the model.
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < CH; c++) begin
                out_valid_i[c] = ($urandom_range(0, 9) < 7);
                in_ready_i[c]  = ($urandom_range(0, 9) < 5);
                out_data_i[c*8 +: 8] = ($urandom_range(0, 7) == 0) ? 8'h0A : 8'($urandom_range(0, 255));
                if ($urandom_range(0, 31) == 0) mode_i[c*2 +: 2] = 2'($urandom_range(0, 3));
            end
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
